// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmit and receive paths:
//     - rx_state_t : receive FSM state encoding
//     - PAR_EVEN / PAR_ODD : values of the PAR_TYP control input
//     - PRESCALE_8/16/32 : legal oversampling ratios
//     - PRESCALE_MIN : smallest ratio the bit timers will honour
//     - majority3() : 2-of-3 vote used for the bit decision
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_8   = 8;
  localparam int PRESCALE_16  = 16;
  localparam int PRESCALE_32  = 32;

  // Below this the three mid-bit sample points would collide with the bit end.
  localparam int PRESCALE_MIN = 4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//   Oversampling bit timer for the UART receiver. While enabled, an edge
//   counter runs 0..P-1 (P = latched prescale, floored at PRESCALE_MIN) and
//   wraps. The synchronized line is captured at P/2-1, P/2 and P/2+1 and the
//   2-of-3 vote is presented together with a bit_end strobe at count P-1.
//
// Ports
//   CLK         in   clock
//   RST         in   synchronous active-high reset (counter only)
//   en          in   1 while the receive FSM is inside a frame
//   rx_s        in   synchronized serial line
//   prescale    in   oversampling ratio latched at start detection
//   sampled_bit out  majority-voted value of the current bit
//   bit_end     out  1 during the last oversample cycle of the current bit
// ---------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  rx_s,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  bit_end
);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] p_eff;
  logic [PRESCALE_W-1:0] last_cnt;
  logic [PRESCALE_W-1:0] half_cnt;
  logic [2:0]            smp_q;
  logic                  smp2_now;

  // Illegal small ratios are clamped so the counter always has a reachable
  // wrap point and the FSM keeps moving.
  always_comb begin
    p_eff = prescale;
    if (prescale < PRESCALE_W'(PRESCALE_MIN)) begin
      p_eff = PRESCALE_W'(PRESCALE_MIN);
    end
    last_cnt = p_eff - 1'b1;
    half_cnt = p_eff >> 1;
  end

  always_ff @(posedge CLK) begin
    if (RST || !en) begin
      edge_cnt <= '0;
    end else if (edge_cnt == last_cnt) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (en) begin
      if (edge_cnt == half_cnt - 1'b1) smp_q[0] <= rx_s;
      if (edge_cnt == half_cnt)        smp_q[1] <= rx_s;
      if (edge_cnt == half_cnt + 1'b1) smp_q[2] <= rx_s;
    end
  end

  // At the minimum ratio the third sample point coincides with the bit end,
  // so the live line value stands in for the not-yet-registered sample.
  assign smp2_now    = (edge_cnt == half_cnt + 1'b1) ? rx_s : smp_q[2];
  assign sampled_bit = majority3(smp_q[0], smp_q[1], smp2_now);
  assign bit_end     = en && (edge_cnt == last_cnt);

endmodule

// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer
//   UART receive path. Synchronizes RX_IN, detects the start bit, times each
//   bit with an oversampling sampler, shifts data in LSB first, checks the
//   optional parity bit and the stop bit, and reports the frame outcome with
//   one-cycle pulses in the cycle after the stop bit ends.
//
// Ports
//   CLK           in   clock (single domain)
//   RST           in   synchronous active-high reset
//   RX_IN         in   asynchronous serial line, idles high
//   Prescale      in   oversampling ratio (8, 16 or 32)
//   PAR_EN        in   1 = a parity bit follows the data bits
//   PAR_TYP       in   0 = even, 1 = odd parity
//   P_DATA        out  last correctly received word
//   Data_Valid    out  pulse: frame received without error
//   Parity_Error  out  pulse: parity mismatch in the frame just ended
//   Stop_Error    out  pulse: stop bit sampled low in the frame just ended
// ---------------------------------------------------------------------------
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [WIDTH-1:0]      P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic                  rx_meta_p0;
  logic                  rx_s;
  rx_state_t             state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_err_pend;
  logic [WIDTH-1:0]      shreg;
  logic                  sampled_bit;
  logic                  bit_end;
  logic                  in_frame;

  function automatic logic parity_expected(input logic [WIDTH-1:0] data,
                                           input logic             typ);
    return (^data) ^ (typ == PAR_ODD);
  endfunction

  // Stage p0 -> rx_s: two-flop synchronizer; reset to the idle (high) level
  // so a reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_meta_p0 <= RX_IN;
      rx_s       <= rx_meta_p0;
    end
  end

  assign in_frame = (state != IDLE);

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .en          (in_frame),
    .rx_s        (rx_s),
    .prescale    (prescale_q),
    .sampled_bit (sampled_bit),
    .bit_end     (bit_end)
  );

  // Frame control, configuration latch and registered result pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      prescale_q   <= PRESCALE_W'(PRESCALE_8);
      par_en_q     <= 1'b0;
      par_typ_q    <= PAR_EVEN;
      par_err_pend <= 1'b0;
      P_DATA       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state        <= START;
            bit_cnt      <= '0;
            prescale_q   <= Prescale;
            par_en_q     <= PAR_EN;
            par_typ_q    <= PAR_TYP;
            par_err_pend <= 1'b0;
          end
        end
        START: begin
          // A start bit that votes high was a glitch: drop it silently.
          if (bit_end) begin
            state <= sampled_bit ? IDLE : DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            par_err_pend <= (sampled_bit != parity_expected(shreg, par_typ_q));
            state        <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
            if (sampled_bit && !par_err_pend) begin
              Data_Valid <= 1'b1;
              P_DATA     <= shreg;
            end else begin
              Stop_Error   <= !sampled_bit;
              Parity_Error <= par_err_pend;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Data shift register: each voted bit enters at the MSB and the word moves
  // right, so the first bit on the line ends up in bit 0.
  always_ff @(posedge CLK) begin
    if (state == DATA && bit_end) begin
      shreg <= WIDTH'({sampled_bit, shreg} >> 1);
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
module tb_uart_rx_deserializer;

  localparam int WIDTH = 8;
  localparam int PW    = 6;

  logic             CLK = 1'b0;
  logic             RST;
  logic             RX_IN;
  logic [PW-1:0]    Prescale;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic [WIDTH-1:0] P_DATA;
  logic             Data_Valid;
  logic             Parity_Error;
  logic             Stop_Error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dv_cnt   = 0;
  int pe_cnt   = 0;
  int se_cnt   = 0;
  int dv_cyc   = 0;
  logic [WIDTH-1:0] dv_data      = '0;
  logic [WIDTH-1:0] prev_dv_data = '0;
  int exp_dv = 0;
  int exp_pe = 0;
  int exp_se = 0;
  int t0;

  uart_rx_deserializer #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .Parity_Error (Parity_Error),
    .Stop_Error   (Stop_Error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (Data_Valid === 1'b1) begin
      dv_cnt       = dv_cnt + 1;
      dv_cyc       = cyc;
      prev_dv_data = dv_data;
      dv_data      = P_DATA;
    end
    if (Parity_Error === 1'b1) pe_cnt = pe_cnt + 1;
    if (Stop_Error === 1'b1)   se_cnt = se_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks = checks + 1;
    assert (obs === expv) else begin
      failures = failures + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic send_bit(input logic b, input int p, input bit glitch);
    for (int i = 0; i < p; i++) begin
      RX_IN = (glitch && i == 2) ? ~b : b;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input bit pen,
                            input logic pbit, input logic stop, input bit glitch);
    send_bit(1'b0, p, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], p, glitch);
    if (pen) send_bit(pbit, p, 1'b0);
    send_bit(stop, p, 1'b0);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_dv"}, dv_cnt, exp_dv);
    chk({tag, "_pe"}, pe_cnt, exp_pe);
    chk({tag, "_se"}, se_cnt, exp_se);
  endtask

  initial begin
    RST      = 1'b1;
    RX_IN    = 1'b1;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Reset state
    chk("rst_pdata", P_DATA, 8'h00);
    chk("rst_dv", Data_Valid, 1'b0);
    chk("rst_pe", Parity_Error, 1'b0);
    chk("rst_se", Stop_Error, 1'b0);
    idle(5);

    // Prescale 8, no parity, 0xA5, latency from falling edge
    t0 = cyc;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(6);
    exp_dv = 1;
    chk_counts("a5");
    chk("a5_pdata", P_DATA, 8'hA5);
    chk("a5_latency", dv_cyc - t0, 83);

    // Prescale 16, even parity, correct parity bit
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(6);
    exp_dv = 2;
    chk_counts("3c_ok");
    chk("3c_ok_pdata", P_DATA, 8'h3C);

    // Wrong parity bit
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(6);
    exp_pe = 1;
    chk_counts("3c_bad");
    chk("3c_bad_pdata", P_DATA, 8'h3C);

    // Odd parity: 0x3D has five ones, so the parity bit is 0
    PAR_TYP = 1'b1;
    send_frame(8'h3D, 16, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(6);
    exp_dv = 3;
    chk_counts("3d_odd");
    chk("3d_odd_pdata", P_DATA, 8'h3D);

    // Prescale 8, stop bit low
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);
    exp_se = 1;
    chk_counts("5a_stop");
    chk("5a_stop_pdata", P_DATA, 8'h3D);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(6);
    exp_dv = 4;
    chk_counts("11");
    chk("11_pdata", P_DATA, 8'h11);

    // Prescale 16, false start of 3 cycles
    Prescale = 6'd16;
    RX_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    idle(40);
    chk_counts("glitch_start");
    chk("glitch_start_pdata", P_DATA, 8'h11);
    send_frame(8'h7E, 16, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(6);
    exp_dv = 5;
    chk_counts("7e");
    chk("7e_pdata", P_DATA, 8'h7E);

    // Prescale 32, back-to-back with glitches away from the sample points
    Prescale = 6'd32;
    send_frame(8'h01, 32, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(8);
    exp_dv = 7;
    chk_counts("b2b");
    chk("b2b_first", prev_dv_data, 8'h01);
    chk("b2b_second", dv_data, 8'hFF);
    chk("b2b_pdata", P_DATA, 8'hFF);

    // Reset in the middle of the data bits of 0xC3
    Prescale = 6'd8;
    send_bit(1'b0, 8, 1'b0);
    send_bit(1'b1, 8, 1'b0);
    send_bit(1'b1, 8, 1'b0);
    send_bit(1'b0, 3, 1'b0);
    RX_IN = 1'b1;
    RST   = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("midrst_pdata", P_DATA, 8'h00);
    chk("midrst_dv", Data_Valid, 1'b0);
    chk("midrst_pe", Parity_Error, 1'b0);
    chk("midrst_se", Stop_Error, 1'b0);
    idle(100);
    chk_counts("midrst_quiet");
    send_frame(8'h24, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(6);
    exp_dv = 8;
    chk_counts("24");
    chk("24_pdata", P_DATA, 8'h24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- UART receive path; the counterpart of the TX serializer.
- Synchronizes the RX_IN line and detects the start bit using Prescale-times oversampling.
- Majority-votes each bit at mid-bit, shifts data in LSB first, and checks optional parity and the stop bit.
- Presents P_DATA with a one-cycle Data_Valid pulse, or flags an error, to the downstream consumer (register file or FIFO).

Parameters:
- WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the Prescale input and of the internal edge counter.

Ports:
- CLK  input  1  clock. One clock domain for the whole block.
- RST  input  1  reset, synchronous, active-high.
- RX_IN  input  1  asynchronous serial line; idles high.
- Prescale  input  PRESCALE_W  oversampling ratio; legal values are 8, 16 and 32.
- PAR_EN  input  1  1 means a parity bit follows the data bits.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  WIDTH  last correctly received data word.
- Data_Valid  output  1  one-cycle pulse when a frame is received without error.
- Parity_Error  output  1  one-cycle pulse at end of frame on parity mismatch.
- Stop_Error  output  1  one-cycle pulse at end of frame when the stop bit samples 0.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - Synchronizer flops = 1, FSM = IDLE, counters = 0.
  - P_DATA = 0; Data_Valid, Parity_Error, Stop_Error = 0.
  - Reset mid-frame abandons the frame with no error pulse.
- Input: RX_IN passes through a 2-flop synchronizer to give rx_s. All timing below refers to rx_s.
- Config latch: Prescale, PAR_EN and PAR_TYP are captured on start detection. Changes during a frame are ignored.
- Counters:
  - edge_cnt runs 0..Prescale-1 in every non-IDLE state, wraps to 0, and marks bit end at Prescale-1.
  - bit_cnt counts data bits 0..WIDTH-1.
- Sampling: rx_s is sampled at edge_cnt = P/2-1, P/2 and P/2+1. Bit value = majority of the 3 samples, used at edge_cnt = P-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s = 0 -> START with edge_cnt = 0.
  - START: at bit end, voted 0 -> DATA. Voted 1 is a glitch -> IDLE, with no outputs and no error.
  - DATA: at each bit end, shift the voted bit in at the MSB and shift right, so the first-received bit lands in P_DATA[0]. After bit WIDTH-1: go to PARITY if PAR_EN, else STOP.
  - PARITY: at bit end, compare the voted bit with the XOR of the shift register, inverted when PAR_TYP = 1. Store a pending parity error.
  - STOP: at bit end, evaluate the frame and go to IDLE.
- Frame result, registered outputs in the cycle after the STOP bit end:
  - Voted stop = 1 and no parity error: Data_Valid = 1 and P_DATA updated in the same cycle.
  - Otherwise: Stop_Error and/or Parity_Error pulse, both may assert together. P_DATA keeps its previous value and Data_Valid = 0.
- P_DATA holds until the next valid frame.
- Back-to-back frames: IDLE accepts a new start in the first cycle after the STOP bit end. No idle gap is required.
- Illegal Prescale values give undefined results and must not hang the FSM. The edge counter wraps at the latched value, minimum 4.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - PAR_EVEN = 0, PAR_ODD = 1.
  - PRESCALE_8/16/32 constants.
  - Shared with the TX side.
- Sub-module uart_rx_sampler:
  - Contains the edge counter, 3-point capture and majority vote.
  - Outputs sampled_bit and bit_end.
  - Enabled by the FSM.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 (line: 0, 1,0,1,0,0,1,0,1, 1) -> exactly one Data_Valid, P_DATA = 0xA5, no errors. Pulse occurs 10×8 cycles (plus synchronizer delay) after the falling edge.
- Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x3C with parity bit 0 -> Data_Valid, P_DATA = 0x3C. Repeat with parity bit 1 -> Parity_Error pulse only, P_DATA stays 0x3C.
- Prescale=8, data 0x5A, stop bit driven 0 -> Stop_Error pulse, Data_Valid = 0, P_DATA unchanged. Then a clean frame 0x11 -> P_DATA = 0x11.
- Prescale=16, RX_IN low for 3 cycles then high -> FSM returns to IDLE, all outputs stay 0. A following valid frame 0x7E is received correctly.
- Prescale=32, frames 0x01 and 0xFF back-to-back with no idle gap, plus 1-cycle glitches injected at non-sample points -> two Data_Valid pulses with P_DATA 0x01 then 0xFF.
- RST asserted for 1 cycle mid-DATA of frame 0xC3 -> all outputs 0 next cycle and no pulses. The next frame 0x24 is received correctly.
